// File: rtl/hex_ascii_streamer_pkg.sv
// Shared constants and state type for the hex ASCII streamer.
// CR/LF states exist only when HEX_STREAM_CRLF_EN is defined.
package hex_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1
`ifdef HEX_STREAM_CRLF_EN
        ,
        CR    = 2'd2,
        LF    = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/hex_ascii_streamer_if.sv
// Word-in / character-out handshake bundle of the hex ASCII streamer.
interface hex_ascii_streamer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_char;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_char
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_char
    );
endinterface

// File: rtl/hex_ascii_streamer_nibble.sv
// Combinational 4-bit value to ASCII hex digit mapper; every code is valid.
module hex_nibble2ascii
    import hex_ascii_pkg::*;
#(
    parameter int LOWERCASE = 0
) (
    input  logic [3:0] nib_i,
    output logic [7:0] char_o
);

    // Digits 0-9 sit at 0x30, letters start at 'A' or 'a' depending on case
    always_comb begin
        char_o = ASCII_ZERO;
        if (nib_i < 4'd10) begin
            char_o = ASCII_ZERO + {4'h0, nib_i};
        end else begin
            char_o = ((LOWERCASE != 0) ? ASCII_A_LO : ASCII_A_UP) + {4'h0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Streams a DATA_W-bit word as ASCII hex, MS nibble first, one char per handshake.
// Define HEX_STREAM_CRLF_EN to append a CR/LF terminator to every word.
module hex_ascii_streamer
    import hex_ascii_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LOWERCASE   = 0,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hex_ascii_streamer_if.slave  bus,
    output logic                 busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic               out_valid_q;
    logic [7:0]         out_char_q;

    logic [IDX_W-1:0]   msnz_idx_s;
    logic [IDX_W-1:0]   start_idx_s;
    logic [IDX_W-1:0]   next_idx_s;
    logic [3:0]         sel_nib_s;
    logic [7:0]         map_char_s;

    // Priority encoder: highest non-zero nibble of the incoming word, 0 when all zero
    always_comb begin
        msnz_idx_s = '0;
        for (int i = 0; i < NIB; i++) begin
            msnz_idx_s = (bus.in_data[4*i +: 4] != 4'h0) ? IDX_W'(i) : msnz_idx_s;
        end
    end

    // One mapper serves both the first char (from in_data) and the following ones (from word_q)
    always_comb begin
        start_idx_s = (LZ_SUPPRESS != 0) ? msnz_idx_s : IDX_W'(NIB - 1);
        next_idx_s  = (idx_q != '0) ? (idx_q - IDX_W'(1)) : '0;
        if (state_q == IDLE) begin
            sel_nib_s = bus.in_data[{start_idx_s, 2'b00} +: 4];
        end else begin
            sel_nib_s = word_q[{next_idx_s, 2'b00} +: 4];
        end
    end

    hex_nibble2ascii #(
        .LOWERCASE (LOWERCASE)
    ) u_map (
        .nib_i  (sel_nib_s),
        .char_o (map_char_s)
    );

    // Control FSM with registered character outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        word_q      <= bus.in_data;
                        idx_q       <= start_idx_s;
                        out_char_q  <= map_char_s;
                        out_valid_q <= 1'b1;
                        state_q     <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (bus.out_ready) begin
                        if (idx_q != '0) begin
                            idx_q      <= next_idx_s;
                            out_char_q <= map_char_s;
                        end else begin
`ifdef HEX_STREAM_CRLF_EN
                            out_char_q <= ASCII_CR;
                            state_q    <= CR;
`else
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
`endif
                        end
                    end
                end
`ifdef HEX_STREAM_CRLF_EN
                CR: begin
                    if (bus.out_ready) begin
                        out_char_q <= ASCII_LF;
                        state_q    <= LF;
                    end
                end
                LF: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
`endif
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign busy          = (state_q != IDLE);

endmodule
